// File: rtl/mdu_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and the iteration count.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  localparam int MDU_STEPS = 32;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide
// sharing one 64-bit accumulator, 32 steps, start/busy/done handshake.
//
// state    | meaning
// MDU_IDLE | waiting for start
// MDU_CALC | one multiply or divide step per cycle
// MDU_DONE | result just written, done pulse; may accept the next start
module mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);
  import mdu_pkg::*;

  localparam logic [4:0] LAST_CNT = 5'(MDU_STEPS - 1);

  mdu_state_t  state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [63:0] acc, acc_n, acc_step;
  logic [31:0] mag, mag_n;
  logic [2:0]  op, op_n;
  logic        neg_main, neg_main_n;
  logic        neg_rem, neg_rem_n;
  logic [31:0] result_q, result_n;

  logic        a_signed, b_signed, sign_a, sign_b;
  logic [31:0] abs_a, abs_b;
  logic        div_zero, div_ovf;

  logic [32:0] sum, rem_sh, diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix, final_word;

  // Operand decode for the request currently on the inputs
  always_comb begin
    a_signed = (funct3 == MDU_MULH) || (funct3 == MDU_MULHSU) ||
               (funct3 == MDU_DIV)  || (funct3 == MDU_REM);
    b_signed = (funct3 == MDU_MULH) || (funct3 == MDU_DIV) || (funct3 == MDU_REM);
    sign_a   = a_signed & operand_a[31];
    sign_b   = b_signed & operand_b[31];
    abs_a    = sign_a ? 32'd0 - operand_a : operand_a;
    abs_b    = sign_b ? 32'd0 - operand_b : operand_b;
    div_zero = funct3[2] && (operand_b == 32'd0);
    div_ovf  = ((funct3 == MDU_DIV) || (funct3 == MDU_REM)) &&
               (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
  end

  // One iteration: upper half is partial product / remainder, lower half
  // is multiplier / dividend shifting out while quotient bits shift in.
  always_comb begin
    sum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag} : 33'd0);
    rem_sh = {acc[63:32], acc[31]};
    diff   = rem_sh - {1'b0, mag};
    if (!op[2])
      acc_step = {sum, acc[31:1]};
    else if (diff[32])
      acc_step = {rem_sh[31:0], acc[30:0], 1'b0};
    else
      acc_step = {diff[31:0], acc[30:0], 1'b1};
  end

  always_comb begin
    prod_fix = neg_main ? 64'd0 - acc_step : acc_step;
    quot_fix = neg_main ? 32'd0 - acc_step[31:0] : acc_step[31:0];
    rem_fix  = neg_rem  ? 32'd0 - acc_step[63:32] : acc_step[63:32];
    case (op)
      MDU_MUL:                         final_word = prod_fix[31:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: final_word = prod_fix[63:32];
      MDU_DIV, MDU_DIVU:               final_word = quot_fix;
      default:                         final_word = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= MDU_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    acc_n      = acc;
    mag_n      = mag;
    op_n       = op;
    neg_main_n = neg_main;
    neg_rem_n  = neg_rem;
    result_n   = result_q;
    case (state)
      MDU_IDLE, MDU_DONE: begin
        state_n = MDU_IDLE;
        if (start) begin
          op_n       = funct3;
          cnt_n      = 5'd0;
          neg_main_n = sign_a ^ sign_b;
          neg_rem_n  = sign_a;
          if (funct3[2]) begin
            acc_n = {32'd0, abs_a};
            mag_n = abs_b;
          end else begin
            acc_n = {32'd0, abs_b};
            mag_n = abs_a;
          end
          if (div_zero) begin
            result_n = funct3[1] ? operand_a : 32'hFFFF_FFFF;
            state_n  = MDU_DONE;
          end else if (div_ovf) begin
            result_n = funct3[1] ? 32'd0 : 32'h8000_0000;
            state_n  = MDU_DONE;
          end else begin
            state_n = MDU_CALC;
          end
        end
      end
      MDU_CALC: begin
        acc_n = acc_step;
        cnt_n = cnt + 5'd1;
        if (cnt == LAST_CNT) begin
          result_n = final_word;
          state_n  = MDU_DONE;
        end
      end
      default: state_n = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= 5'd0;
      acc      <= 64'd0;
      mag      <= 32'd0;
      op       <= MDU_MUL;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= 32'd0;
    end else begin
      cnt      <= cnt_n;
      acc      <= acc_n;
      mag      <= mag_n;
      op       <= op_n;
      neg_main <= neg_main_n;
      neg_rem  <= neg_rem_n;
      result_q <= result_n;
    end
  end

  assign result = result_q;
  assign busy   = (state == MDU_CALC);
  assign done   = (state == MDU_DONE);

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vector table, handshake/reset
// sequences, and randomized ops against a plain-arithmetic reference.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [31:0] operand_a, operand_b, result;
  logic        busy, done;

  int n_cmp  = 0;
  int n_fail = 0;

  mdu dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: RV32M semantics with 64-bit integer arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    p  = 64'd0;
    case (f)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'b101: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'b110: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called just after a negedge; returns at the negedge where done is seen
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bcnt);
    start = 1'b1; funct3 = f; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0; funct3 = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
    lat = 1; bcnt = 0;
    while (!done && lat < 60) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, exp, a, b;
    logic [2:0]  f;
    int          lat, bcnt, gap;

    reset = 1'b1; start = 1'b0; funct3 = 3'd0; operand_a = 32'd0; operand_b = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_result", result, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    tbl[0]  = '{3'b000, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    tbl[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    tbl[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    tbl[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    tbl[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33};
    tbl[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33};
    tbl[6]  = '{3'b111, 32'hFFFF_FFF9, 32'h2,         32'h1,         33};
    tbl[7]  = '{3'b101, 32'h5,         32'h0,         32'hFFFF_FFFF, 1};
    tbl[8]  = '{3'b110, 32'h5,         32'h0,         32'h5,         1};
    tbl[9]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[10] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
    tbl[11] = '{3'b101, 32'd100,       32'd7,         32'd14,        33};

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].f, tbl[i].a, tbl[i].b, res, lat, bcnt);
      check($sformatf("vec%0d_result", i), res, tbl[i].exp);
      check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, (tbl[i].lat == 33) ? 32 : 0);
      @(negedge clk);
      check($sformatf("vec%0d_done_one_cycle", i), done, 0);
    end

    // start during CALC must be ignored
    start = 1'b1; funct3 = 3'b000; operand_a = 32'h7; operand_b = 32'hFFFF_FFFD;
    @(negedge clk);
    start = 1'b0; lat = 1;
    repeat (9) begin @(negedge clk); lat++; end
    start = 1'b1; funct3 = 3'b101; operand_a = 32'd100; operand_b = 32'd7;
    @(negedge clk);
    lat++; start = 1'b0;
    while (!done && lat < 60) begin @(negedge clk); lat++; end
    check("ignore_result", result, 32'hFFFF_FFEB);
    check("ignore_latency", lat, 33);
    @(negedge clk);
    check("ignore_not_queued_busy", busy, 0);
    check("ignore_not_queued_done", done, 0);

    // start held in the DONE cycle issues back to back
    run_op(3'b000, 32'd3, 32'd5, res, lat, bcnt);
    check("b2b_first_result", res, 32'd15);
    check("b2b_first_latency", lat, 33);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, res, lat, bcnt);
    check("b2b_second_result", res, 32'hFFFF_FFFD);
    check("b2b_second_latency", lat, 33);
    check("b2b_second_busy_cycles", bcnt, 32);
    @(negedge clk);

    // reset at CALC iteration 10
    start = 1'b1; funct3 = 3'b101; operand_a = 32'd100; operand_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    run_op(3'b101, 32'd100, 32'd7, res, lat, bcnt);
    check("post_reset_result", res, 32'd14);
    check("post_reset_latency", lat, 33);
    @(negedge clk);

    // randomized ops, random gaps (gap 0 issues in the DONE cycle)
    for (int i = 0; i < 300; i++) begin
      f = 3'($urandom);
      a = pick_val();
      b = pick_val();
      exp = ref_mdu(f, a, b);
      run_op(f, a, b, res, lat, bcnt);
      check($sformatf("rand%0d_f%0d_a%0h_b%0h_result", i, f, a, b), res, exp);
      check($sformatf("rand%0d_f%0d_latency", i, f), lat, ref_lat(f, a, b));
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        @(negedge clk);
        check($sformatf("rand%0d_done_one_cycle", i), done, 0);
        repeat (gap - 1) @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
